// File: rtl/flex_accum_counter_if.sv
// Control/status bundle for flex_accum_counter: the packer drives step and limit
// programming, the counter returns its running count and flags.
interface flex_accum_counter_if #(
  parameter int NUM_CNT_BITS = 8,
  parameter int STEP_BITS    = 4,
  parameter int WRAP_BITS    = 8
);
  logic                    clear;
  logic                    count_enable;
  logic [STEP_BITS-1:0]    step;
  logic [NUM_CNT_BITS-1:0] rollover_val;
  logic                    sat_mode;
  logic [NUM_CNT_BITS-1:0] count_out;
  logic                    rollover_flag;
  logic [WRAP_BITS-1:0]    wrap_count;
  logic                    sat_flag;
  logic                    err_flag;

  modport master (
    output clear, count_enable, step, rollover_val, sat_mode,
    input  count_out, rollover_flag, wrap_count, sat_flag, err_flag
  );

  modport slave (
    input  clear, count_enable, step, rollover_val, sat_mode,
    output count_out, rollover_flag, wrap_count, sat_flag, err_flag
  );
endinterface

// File: rtl/flex_accum_counter.sv
// Variable-step accumulating counter with runtime-programmable modulus or ceiling,
// wrap counting and sticky saturation/programming-error flags.
module flex_accum_counter #(
  parameter int NUM_CNT_BITS = 8,
  parameter int STEP_BITS    = 4,
  parameter int WRAP_BITS    = 8
) (
  input  logic                clk,
  input  logic                n_rst,
  flex_accum_counter_if.slave bus
);
  localparam int SUM_W = NUM_CNT_BITS + 1;
  localparam int CMP_W = (STEP_BITS > NUM_CNT_BITS) ? STEP_BITS : NUM_CNT_BITS;

  logic [NUM_CNT_BITS-1:0] count_r, count_nxt_s;
  logic [WRAP_BITS-1:0]    wrap_r, wrap_nxt_s;
  logic                    roll_r, roll_nxt_s;
  logic                    sat_r, sat_nxt_s;
  logic                    err_r, err_nxt_s;

  logic [SUM_W-1:0]        sum_s;
  logic [SUM_W-1:0]        limit_s;
  logic [CMP_W-1:0]        step_ext_s;
  logic [CMP_W-1:0]        limit_ext_s;
  logic                    over_s;

  // Next-state evaluation: clear beats enable beats hold; error checks precede mode logic
  always_comb begin
    count_nxt_s = count_r;
    wrap_nxt_s  = wrap_r;
    roll_nxt_s  = 1'b0;
    sat_nxt_s   = sat_r;
    err_nxt_s   = err_r;

    sum_s       = {1'b0, count_r} + SUM_W'(bus.step);
    limit_s     = {1'b0, bus.rollover_val};
    step_ext_s  = CMP_W'(bus.step);
    limit_ext_s = CMP_W'(bus.rollover_val);
    // A count parked exactly at the ceiling is legal only while saturating
    if (bus.sat_mode) begin
      over_s = (count_r > bus.rollover_val);
    end else begin
      over_s = (count_r >= bus.rollover_val);
    end

    if (bus.clear) begin
      count_nxt_s = '0;
      wrap_nxt_s  = '0;
      sat_nxt_s   = 1'b0;
      err_nxt_s   = 1'b0;
    end else if (bus.count_enable) begin
      if (bus.rollover_val == '0) begin
        count_nxt_s = '0;
        err_nxt_s   = 1'b1;
      end else if (over_s) begin
        count_nxt_s = '0;
        err_nxt_s   = 1'b1;
      end else if (!bus.sat_mode && (step_ext_s > limit_ext_s)) begin
        err_nxt_s   = 1'b1;
      end else if (sum_s >= limit_s) begin
        if (bus.sat_mode) begin
          count_nxt_s = bus.rollover_val;
          sat_nxt_s   = 1'b1;
        end else begin
          // count < limit and step <= limit, so the remainder fits below the limit
          count_nxt_s = NUM_CNT_BITS'(sum_s - limit_s);
          roll_nxt_s  = 1'b1;
          if (wrap_r != '1) begin
            wrap_nxt_s = wrap_r + WRAP_BITS'(1'b1);
          end else begin
            wrap_nxt_s = wrap_r;
          end
        end
      end else begin
        count_nxt_s = NUM_CNT_BITS'(sum_s);
      end
    end else begin
      count_nxt_s = count_r;
    end
  end

  // State registers, asynchronously cleared
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_r <= '0;
      wrap_r  <= '0;
      roll_r  <= 1'b0;
      sat_r   <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      wrap_r  <= wrap_nxt_s;
      roll_r  <= roll_nxt_s;
      sat_r   <= sat_nxt_s;
      err_r   <= err_nxt_s;
    end
  end

  assign bus.count_out     = count_r;
  assign bus.wrap_count    = wrap_r;
  assign bus.rollover_flag = roll_r;
  assign bus.sat_flag      = sat_r;
  assign bus.err_flag      = err_r;
endmodule

// File: tb/tb_flex_accum_counter.sv
// Directed, table-driven bench for flex_accum_counter plus hand sequences for
// asynchronous reset and wrap_count saturation on a narrow-counter instance.
module tb_flex_accum_counter;
  logic clk;
  logic n_rst;

  flex_accum_counter_if #(.NUM_CNT_BITS(8), .STEP_BITS(4), .WRAP_BITS(8)) bus1 ();
  flex_accum_counter_if #(.NUM_CNT_BITS(8), .STEP_BITS(4), .WRAP_BITS(2)) bus2 ();

  flex_accum_counter #(.NUM_CNT_BITS(8), .STEP_BITS(4), .WRAP_BITS(8)) dut1 (
    .clk(clk), .n_rst(n_rst), .bus(bus1.slave));
  flex_accum_counter #(.NUM_CNT_BITS(8), .STEP_BITS(4), .WRAP_BITS(2)) dut2 (
    .clk(clk), .n_rst(n_rst), .bus(bus2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       en;
    logic [3:0] step;
    logic [7:0] rv;
    logic       sat;
    logic [7:0] c;
    logic       r;
    logic [7:0] w;
    logic       s;
    logic       e;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input int idx, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic chk1(input int idx, input logic [7:0] c, input logic r,
                      input logic [7:0] w, input logic s, input logic e);
    chk("count_out", idx, int'(bus1.count_out), int'(c));
    chk("rollover_flag", idx, int'(bus1.rollover_flag), int'(r));
    chk("wrap_count", idx, int'(bus1.wrap_count), int'(w));
    chk("sat_flag", idx, int'(bus1.sat_flag), int'(s));
    chk("err_flag", idx, int'(bus1.err_flag), int'(e));
  endtask

  task automatic add(input logic clr, input logic en, input logic [3:0] step,
                     input logic [7:0] rv, input logic sat, input logic [7:0] c,
                     input logic r, input logic [7:0] w, input logic s, input logic e);
    vec_t v;
    v.clr = clr; v.en = en; v.step = step; v.rv = rv; v.sat = sat;
    v.c = c; v.r = r; v.w = w; v.s = s; v.e = e;
    tbl.push_back(v);
  endtask

  task automatic drive1(input logic clr, input logic en, input logic [3:0] step,
                        input logic [7:0] rv, input logic sat);
    bus1.clear = clr; bus1.count_enable = en; bus1.step = step;
    bus1.rollover_val = rv; bus1.sat_mode = sat;
  endtask

  initial begin
    //   clr   en    step   rv      sat  | count  roll  wrap  sat   err
    add(1'b0, 1'b1, 4'd3, 8'd8,  1'b0, 8'd3,  1'b0, 8'd0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 4'd3, 8'd8,  1'b0, 8'd6,  1'b0, 8'd0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 4'd3, 8'd8,  1'b0, 8'd1,  1'b1, 8'd1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 4'd5, 8'd8,  1'b0, 8'd6,  1'b0, 8'd1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 4'd4, 8'd8,  1'b0, 8'd2,  1'b1, 8'd2, 1'b0, 1'b0);
    add(1'b1, 1'b0, 4'd0, 8'd8,  1'b0, 8'd0,  1'b0, 8'd0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 4'd4, 8'd10, 1'b1, 8'd4,  1'b0, 8'd0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 4'd4, 8'd10, 1'b1, 8'd8,  1'b0, 8'd0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 4'd4, 8'd10, 1'b1, 8'd10, 1'b0, 8'd0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 4'd1, 8'd10, 1'b1, 8'd10, 1'b0, 8'd0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 4'd1, 8'd10, 1'b1, 8'd10, 1'b0, 8'd0, 1'b1, 1'b0);
    add(1'b1, 1'b0, 4'd0, 8'd8,  1'b0, 8'd0,  1'b0, 8'd0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 4'd5, 8'd8,  1'b0, 8'd5,  1'b0, 8'd0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 4'd2, 8'd8,  1'b0, 8'd0,  1'b0, 8'd0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 4'd3, 8'd8,  1'b0, 8'd3,  1'b0, 8'd0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      add(1'b0, 1'b0, 4'd7, 8'd8, 1'b0, 8'd3,  1'b0, 8'd0, 1'b0, 1'b0);
    end
    add(1'b1, 1'b0, 4'd0, 8'd6,  1'b0, 8'd0,  1'b0, 8'd0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 4'd5, 8'd6,  1'b0, 8'd5,  1'b0, 8'd0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 4'd1, 8'd4,  1'b0, 8'd0,  1'b0, 8'd0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 4'd7, 8'd4,  1'b0, 8'd0,  1'b0, 8'd0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 4'd0, 8'd4,  1'b0, 8'd0,  1'b0, 8'd0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 4'd2, 8'd4,  1'b0, 8'd2,  1'b0, 8'd0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 4'd7, 8'd4,  1'b0, 8'd2,  1'b0, 8'd0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 4'd1, 8'd0,  1'b0, 8'd0,  1'b0, 8'd0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 4'd0, 8'd4,  1'b1, 8'd0,  1'b0, 8'd0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 4'd7, 8'd4,  1'b1, 8'd4,  1'b0, 8'd0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 4'd1, 8'd4,  1'b0, 8'd0,  1'b0, 8'd0, 1'b1, 1'b1);

    n_rst = 1'b0;
    drive1(1'b0, 1'b0, 4'd0, 8'd8, 1'b0);
    bus2.clear = 1'b0; bus2.count_enable = 1'b0; bus2.step = 4'd0;
    bus2.rollover_val = 8'd1; bus2.sat_mode = 1'b0;
    #12;
    chk1(-1, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    n_rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive1(tbl[i].clr, tbl[i].en, tbl[i].step, tbl[i].rv, tbl[i].sat);
      @(posedge clk);
      #1;
      chk1(i, tbl[i].c, tbl[i].r, tbl[i].w, tbl[i].s, tbl[i].e);
    end

    // Asynchronous reset between edges, with a nonzero count and a pending wrap
    @(negedge clk);
    drive1(1'b0, 1'b1, 4'd3, 8'd8, 1'b0);
    @(posedge clk);
    #1;
    chk1(100, 8'd3, 1'b0, 8'd0, 1'b1, 1'b1);
    @(negedge clk);
    drive1(1'b0, 1'b1, 4'd6, 8'd8, 1'b0);
    @(posedge clk);
    #2;
    chk1(101, 8'd1, 1'b1, 8'd1, 1'b1, 1'b1);
    n_rst = 1'b0;
    #1;
    chk1(102, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    n_rst = 1'b1;
    drive1(1'b0, 1'b0, 4'd0, 8'd8, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk1(103 + k, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    end

    // Narrow wrap counter: a wrap every cycle, count saturates at 3
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus2.count_enable = 1'b1; bus2.step = 4'd1; bus2.rollover_val = 8'd1;
      @(posedge clk);
      #1;
      chk("w2_rollover_flag", 200 + k, int'(bus2.rollover_flag), 1);
      chk("w2_wrap_count", 200 + k, int'(bus2.wrap_count), (k < 3) ? k + 1 : 3);
      chk("w2_count_out", 200 + k, int'(bus2.count_out), 0);
    end
    @(negedge clk);
    bus2.count_enable = 1'b0;
    @(posedge clk);
    #1;
    chk("w2_pulse_drop", 206, int'(bus2.rollover_flag), 0);
    chk("w2_wrap_hold", 206, int'(bus2.wrap_count), 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
